// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch, decode and execute of
// LW/SW/R-type/BEQ/ADDI/J and decodes datapath controls from the current state.
module mips_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       branch,
    output logic       illegal_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 2'b00;
        pc_src     = 2'b00;
        unique case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                // Strobes gated by rst_n so reset never latches IR or PC.
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_main_control.sv
// Directed bench: driver pushes the expected state/outputs of each cycle into
// a queue, a negedge monitor pops and compares against the DUT.
module tb_mips_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_write, reg_write, iord, reg_dst;
    logic       mem_to_reg, alu_src_a, branch, illegal_op;
    logic [1:0] alu_src_b, alu_ctrl, pc_src;
    logic [3:0] state;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    int checks = 0;
    int errors = 0;
    int step = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    mips_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .iord(iord), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .branch(branch),
        .illegal_op(illegal_op), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .state(state)
    );

    // {state, pc_write, ir_write, mem_write, reg_write, iord, reg_dst,
    //  mem_to_reg, alu_src_a, branch, illegal_op, alu_src_b, alu_ctrl, pc_src}
    function automatic logic [19:0] expect_vec(input logic [3:0] st, input logic mr,
                                               input logic rst, input logic [5:0] op);
        logic [9:0] b;
        logic [1:0] sb, ac, ps;
        b = '0; sb = 2'b00; ac = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin sb = 2'b01; b[9] = mr & rst; b[8] = mr & rst; end
            4'd1:  begin
                sb = 2'b11;
                b[0] = !(op == LW || op == SW || op == RT || op == BEQ ||
                         op == ADDI || op == JMP);
            end
            4'd2:  begin b[2] = 1'b1; sb = 2'b10; end
            4'd3:  b[5] = 1'b1;
            4'd4:  begin b[3] = 1'b1; b[6] = 1'b1; end
            4'd5:  begin b[5] = 1'b1; b[7] = 1'b1; end
            4'd6:  begin b[2] = 1'b1; ac = 2'b10; end
            4'd7:  begin b[4] = 1'b1; b[6] = 1'b1; end
            4'd8:  begin b[2] = 1'b1; ac = 2'b01; ps = 2'b01; b[1] = 1'b1; end
            4'd9:  begin b[2] = 1'b1; sb = 2'b10; end
            4'd10: b[6] = 1'b1;
            4'd11: begin ps = 2'b10; b[9] = 1'b1; end
            default: ;
        endcase
        return {st, b, sb, ac, ps};
    endfunction

    // One cycle: set inputs between edges, record what the DUT must show.
    task automatic cyc(input logic rst, input logic mr, input logic [5:0] op,
                       input logic [3:0] exp_state);
        @(posedge clk);
        #1;
        rst_n = rst;
        mem_ready = mr;
        opcode = op;
        exp_q.push_back(expect_vec(exp_state, mr, rst, op));
    endtask

    always @(negedge clk) begin
        logic [19:0] act, exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {state, pc_write, ir_write, mem_write, reg_write, iord, reg_dst,
                   mem_to_reg, alu_src_a, branch, illegal_op, alu_src_b, alu_ctrl, pc_src};
            checks++;
            step++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                         step, act[19:16], act[15:0], exp[19:16], exp[15:0]);
            end
        end
    end

    initial begin
        // Reset, then FETCH stall with strobes low
        cyc(0, 0, RT, 0); cyc(0, 1, RT, 0);
        cyc(1, 0, RT, 0); cyc(1, 0, RT, 0); cyc(1, 0, RT, 0);
        // LW
        cyc(1, 1, LW, 0); cyc(1, 1, LW, 1); cyc(1, 1, LW, 2);
        cyc(1, 1, LW, 3); cyc(1, 1, LW, 4);
        // SW with two stall cycles in MEMWR
        cyc(1, 1, SW, 0); cyc(1, 1, SW, 1); cyc(1, 1, SW, 2);
        cyc(1, 0, SW, 5); cyc(1, 0, SW, 5); cyc(1, 1, SW, 5);
        // R-type
        cyc(1, 1, RT, 0); cyc(1, 1, RT, 1); cyc(1, 1, RT, 6); cyc(1, 1, RT, 7);
        // BEQ
        cyc(1, 1, BEQ, 0); cyc(1, 1, BEQ, 1); cyc(1, 1, BEQ, 8);
        // ADDI
        cyc(1, 1, ADDI, 0); cyc(1, 1, ADDI, 1); cyc(1, 1, ADDI, 9); cyc(1, 1, ADDI, 10);
        // J
        cyc(1, 1, JMP, 0); cyc(1, 1, JMP, 1); cyc(1, 1, JMP, 11);
        // Illegal opcode, then a stalled fetch
        cyc(1, 1, BAD, 0); cyc(1, 1, BAD, 1); cyc(1, 0, BAD, 0);
        // LW with MEMRD stall and MEMRD-side memory wait
        cyc(1, 1, LW, 0); cyc(1, 1, LW, 1); cyc(1, 1, LW, 2);
        cyc(1, 0, LW, 3); cyc(1, 1, LW, 3); cyc(1, 1, LW, 4);
        // Async reset between edges while stalled in MEMRD
        cyc(1, 1, LW, 0); cyc(1, 1, LW, 1); cyc(1, 1, LW, 2); cyc(1, 0, LW, 3);
        cyc(0, 0, LW, 0); cyc(0, 1, LW, 0);
        cyc(1, 1, LW, 0); cyc(1, 1, LW, 1); cyc(1, 1, LW, 2);
        // Async reset while stalled in MEMWR
        cyc(1, 1, SW, 3); cyc(1, 1, SW, 4);
        cyc(1, 1, SW, 0); cyc(1, 1, SW, 1); cyc(1, 1, SW, 2); cyc(1, 0, SW, 5);
        cyc(0, 0, SW, 0);
        cyc(1, 1, SW, 0); cyc(1, 1, SW, 1);
        cyc(1, 0, SW, 2); cyc(1, 0, SW, 5); cyc(1, 1, SW, 5); cyc(1, 0, RT, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles never compared, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
